spi_regfile_periph: RTL

Parametrised SPI mode-0 peripheral that writes and reads back a bank of `NUM_REGS` control registers of `DATA_W` bits. It is the successor of the 5-register write-only SPI control peripheral: the register count and width are parametrised, frames are length-checked, and read access is added on CIPO. It sits between the chip's SPI pins and the output-enable / PWM configuration logic, which consumes the flattened register bus.

---
 rtl/spi_regfile_periph.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 register bank: length-checked write frames, optional readback on CIPO.
// Define SPI_READBACK_EN to build the read shift register; otherwise CIPO/CIPO_oe are tied low.
module spi_regfile_periph #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCLK,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic                       CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int WARM_W  = SYNC_STAGES + 2;

  logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, copi_sync_q;
  logic                   ncs_prev_q, sclk_prev_q;
  logic                   copi_bit_q, ncs_low_q;
  logic                   sclk_rise_q, ncs_fall_q, ncs_rise_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   in_frame_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_W-1:0]     shift_q;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]    wr_en;
  logic [NUM_REGS-1:0]    wr_strobe_q;
  logic                   frame_err_q;
  logic                   frame_exact;
  logic                   commit_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync_q  <= '1;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
      copi_bit_q  <= 1'b0;
      ncs_low_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      ncs_fall_q  <= 1'b0;
      ncs_rise_q  <= 1'b0;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
      ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      copi_bit_q  <= copi_sync_q[SYNC_STAGES-1];
      ncs_low_q   <= ~ncs_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      ncs_fall_q  <= ~ncs_sync_q[SYNC_STAGES-1] & ncs_prev_q;
      ncs_rise_q  <= ncs_sync_q[SYNC_STAGES-1] & ~ncs_prev_q;
    end
  end

  assign frame_exact = ncs_rise_q & in_frame_q & (cnt_q == CNT_W'(FRAME_W));
  assign commit_wr   = frame_exact & shift_q[FRAME_W-1];

  // A low nCS seen right after reset looks like a falling edge; warm_q ignores it so an aborted frame stays silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q      <= '0;
      in_frame_q  <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      warm_q      <= {warm_q[WARM_W-2:0], 1'b1};
      wr_strobe_q <= wr_en;
      frame_err_q <= ncs_rise_q & in_frame_q & (cnt_q != CNT_W'(FRAME_W)) & (cnt_q != '0);
      if (ncs_fall_q) begin
        in_frame_q <= warm_q[WARM_W-1];
        cnt_q      <= '0;
        shift_q    <= '0;
      end else if (ncs_rise_q) begin
        in_frame_q <= 1'b0;
      end else if (sclk_rise_q && ncs_low_q && in_frame_q) begin
        if (cnt_q != CNT_W'(FRAME_W + 1))
          cnt_q <= cnt_q + CNT_W'(1);
        shift_q <= {shift_q[FRAME_W-2:0], copi_bit_q};
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_en[gi] = commit_wr & (shift_q[DATA_W +: ADDR_W] == ADDR_W'(gi));
      always_ff @(posedge clk) begin
        if (rst)
          regs_q[gi] <= '0;
        else if (wr_en[gi])
          regs_q[gi] <= shift_q[DATA_W-1:0];
      end
      assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

  assign wr_strobe = wr_strobe_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  logic              sclk_fall_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_src;
  logic              rd_loaded_q;
  logic              cipo_q;

  always_comb begin
    rd_src = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (shift_q[ADDR_W-1:0] == ADDR_W'(k))
        rd_src = regs_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_fall_q <= 1'b0;
      rd_q        <= '0;
      rd_loaded_q <= 1'b0;
      cipo_q      <= 1'b0;
    end else begin
      sclk_fall_q <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
      if (ncs_fall_q || ncs_rise_q) begin
        rd_q        <= '0;
        rd_loaded_q <= 1'b0;
        cipo_q      <= 1'b0;
      end else if (sclk_fall_q && ncs_low_q && in_frame_q) begin
        if (!rd_loaded_q && cnt_q == CNT_W'(1 + ADDR_W) && !shift_q[ADDR_W]) begin
          rd_q        <= rd_src;
          rd_loaded_q <= 1'b1;
          cipo_q      <= rd_src[DATA_W-1];
        end else if (rd_loaded_q) begin
          rd_q   <= {rd_q[DATA_W-2:0], 1'b0};
          cipo_q <= rd_q[DATA_W-2];
        end
      end
    end
  end

  assign CIPO    = cipo_q;
  assign CIPO_oe = rd_loaded_q;
`else
  assign CIPO    = 1'b0;
  assign CIPO_oe = 1'b0;
`endif

endmodule
